jk_excite_driver: RTL and testbench

Driver side for the JKff flip-flop bank: it accepts a requested N-bit target state and computes per-bit J/K inputs from the JK excitation table and the bank's current Q. It pulses the bank's enable for exactly one cycle, then checks that Q reached the target and reports done or error. It sits between sequencing logic (counters, test sequencers) and a WIDTH-wide bank of JKff instances sharing the same clock.

---
 rtl/jk_excite_driver.sv | 126 ++++++++++++
 tb/tb_jk_excite_driver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/jk_excite_driver.sv
// Drives a bank of JK flip-flops toward a requested target state, then checks the result.
// Optional macro JKDRV_RETRY_EN re-drives the bank up to MAX_RETRY times after a mismatch.
module jk_excite_driver #(
    parameter int   WIDTH     = 4,
    parameter logic DC_FILL   = 1'b0,
    parameter int   MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_target,
    output logic             req_ready,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] ff_j,
    output logic [WIDTH-1:0] ff_k,
    output logic             ff_enable,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] err_mask
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] exc_target;
    logic [WIDTH-1:0] dc_vec;
    logic [WIDTH-1:0] j_next;
    logic [WIDTH-1:0] k_next;
    logic [WIDTH-1:0] mismatch;

    if (MAX_RETRY < 0) begin : g_bad_max_retry
        $error("MAX_RETRY must be non-negative");
    end

`ifdef JKDRV_RETRY_EN
    localparam int CW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [CW-1:0] retry_cnt;
`endif

    // Excitation uses the incoming target on accept and the latched target on a retry.
    always_comb begin
        exc_target = (state == IDLE) ? req_target : target;
        dc_vec     = {WIDTH{DC_FILL}};
        j_next     = (~q_in & exc_target) | (q_in & dc_vec);
        k_next     = (q_in & ~exc_target) | (~q_in & dc_vec);
        mismatch   = q_in ^ target;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            target    <= '0;
            ff_j      <= '0;
            ff_k      <= '0;
            ff_enable <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_mask  <= '0;
            req_ready <= 1'b0;
`ifdef JKDRV_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        target    <= req_target;
                        ff_j      <= j_next;
                        ff_k      <= k_next;
                        ff_enable <= 1'b1;
                        req_ready <= 1'b0;
                        err_mask  <= '0;
                        state     <= DRIVE;
`ifdef JKDRV_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end
                end
                DRIVE: begin
                    ff_enable <= 1'b0;
                    ff_j      <= '0;
                    ff_k      <= '0;
                    state     <= CHECK;
                end
                CHECK: begin
                    if (mismatch == '0) begin
                        done      <= 1'b1;
                        err_mask  <= '0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
`ifdef JKDRV_RETRY_EN
                        if (retry_cnt < CW'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + CW'(1);
                            ff_j      <= j_next;
                            ff_k      <= k_next;
                            ff_enable <= 1'b1;
                            state     <= DRIVE;
                        end else begin
                            error     <= 1'b1;
                            err_mask  <= mismatch;
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end
`else
                        error     <= 1'b1;
                        err_mask  <= mismatch;
                        req_ready <= 1'b1;
                        state     <= IDLE;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_excite_driver.sv
// Directed bench for jk_excite_driver: two drivers (DC_FILL 0 and 1) each steering a modelled JK bank.
// Expected pulse count and result latency for the stuck-bank case follow JKDRV_RETRY_EN.
module tb_jk_excite_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [3:0] req_target;
    logic       bank_clear;

    logic       ready0, en0, done0, error0;
    logic [3:0] j0, k0, mask0;
    logic [3:0] q0 = 4'b0000;

    logic       ready1, en1, done1, error1;
    logic [3:0] j1, k1, mask1;
    logic [3:0] q1 = 4'b0000;

    int checks = 0;
    int errors = 0;

`ifdef JKDRV_RETRY_EN
    localparam int EXP_PULSES = 4;
    localparam int EXP_RESULT_CYCLE = 8;
`else
    localparam int EXP_PULSES = 1;
    localparam int EXP_RESULT_CYCLE = 2;
`endif

    jk_excite_driver #(.WIDTH(4), .DC_FILL(1'b0), .MAX_RETRY(3)) u0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_target(req_target),
        .req_ready(ready0), .q_in(q0), .ff_j(j0), .ff_k(k0), .ff_enable(en0),
        .done(done0), .error(error0), .err_mask(mask0)
    );

    jk_excite_driver #(.WIDTH(4), .DC_FILL(1'b1), .MAX_RETRY(3)) u1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_target(req_target),
        .req_ready(ready1), .q_in(q1), .ff_j(j1), .ff_k(k1), .ff_enable(en1),
        .done(done1), .error(error1), .err_mask(mask1)
    );

    always #5 clk = ~clk;

    // Behavioural JK bank: Q+ = J&~Q | ~K&Q when enabled, forced to zero while cleared.
    always @(posedge clk) begin
        if (bank_clear) q0 <= 4'b0000;
        else if (en0)   q0 <= (j0 & ~q0) | (~k0 & q0);
        if (bank_clear) q1 <= 4'b0000;
        else if (en1)   q1 <= (j1 & ~q1) | (~k1 & q1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady();
        int n = 0;
        while (!ready0 && n < 20) begin
            tick();
            n++;
        end
        if (!ready0) checkOutput("ready_timeout", 32'd0, 32'd1);
    endtask

    // One full accept/drive/check sequence expected to end in done.
    task automatic applyStimulus(input string tag, input logic [3:0] tgt,
                                 input logic [3:0] ej0, input logic [3:0] ek0,
                                 input logic [3:0] ej1, input logic [3:0] ek1);
        waitReady();
        req_valid  = 1'b1;
        req_target = tgt;
        tick();
        req_valid = 1'b0;
        checkOutput({tag, "_en_e0"}, en0, 1);
        checkOutput({tag, "_j0"}, j0, ej0);
        checkOutput({tag, "_k0"}, k0, ek0);
        checkOutput({tag, "_j1"}, j1, ej1);
        checkOutput({tag, "_k1"}, k1, ek1);
        checkOutput({tag, "_ready_e0"}, ready0, 0);
        tick();
        checkOutput({tag, "_en_e1"}, en0, 0);
        checkOutput({tag, "_jk_clr"}, {j0, k0, j1, k1}, 0);
        checkOutput({tag, "_q0"}, q0, tgt);
        checkOutput({tag, "_q1"}, q1, tgt);
        checkOutput({tag, "_done_e1"}, done0, 0);
        tick();
        checkOutput({tag, "_done0"}, done0, 1);
        checkOutput({tag, "_done1"}, done1, 1);
        checkOutput({tag, "_error"}, error0, 0);
        checkOutput({tag, "_mask"}, mask0, 0);
        checkOutput({tag, "_ready_e2"}, ready0, 1);
        tick();
        checkOutput({tag, "_done_e3"}, done0, 0);
        checkOutput({tag, "_en_e3"}, en0, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] tbl [0:8];
        int pulses;
        int result_cycle;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_target = 4'b0000;
        bank_clear = 1'b0;

        // Reset state.
        tick();
        tick();
        checkOutput("rst_enable", en0, 0);
        checkOutput("rst_outputs", {done0, error0, mask0, j0, k0}, 0);
        checkOutput("rst_ready", ready0, 0);
        reset = 1'b0;
        tick();
        checkOutput("rst_ready_release", ready0, 1);

        // Reset in the middle of a drive.
        req_valid  = 1'b1;
        req_target = 4'b0101;
        tick();
        req_valid = 1'b0;
        checkOutput("mid_en", en0, 1);
        checkOutput("mid_j", j0, 4'b0101);
        reset = 1'b1;
        tick();
        checkOutput("mid_rst_en", en0, 0);
        checkOutput("mid_rst_outs", {done0, error0, mask0, j0, k0, ready0}, 0);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("mid_ready_release", ready0, 1);
        checkOutput("mid_no_done", {done0, error0}, 0);
        bank_clear = 1'b1;
        tick();
        bank_clear = 1'b0;

        // Normal drives; u1 shows the DC_FILL=1 excitation.
        applyStimulus("set1010", 4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b1111);
        applyStimulus("to0110",  4'b0110, 4'b0100, 4'b1000, 4'b1110, 4'b1101);
        applyStimulus("hold",    4'b0110, 4'b0000, 4'b0000, 4'b0110, 4'b1001);

        // Bank stuck in clear: target can never be reached.
        bank_clear = 1'b1;
        tick();
        waitReady();
        req_valid  = 1'b1;
        req_target = 4'b0001;
        tick();
        req_valid = 1'b0;
        checkOutput("stuck_j", j0, 4'b0001);
        checkOutput("stuck_k", k0, 4'b0000);
        pulses = 0;
        result_cycle = -1;
        for (int c = 0; c < 30; c++) begin
            if (en0) pulses++;
            if (error0 || done0) begin
                result_cycle = c;
                break;
            end
            tick();
        end
        checkOutput("stuck_pulses", pulses, EXP_PULSES);
        checkOutput("stuck_latency", result_cycle, EXP_RESULT_CYCLE);
        checkOutput("stuck_error", error0, 1);
        checkOutput("stuck_done", done0, 0);
        checkOutput("stuck_mask", mask0, 4'b0001);
        bank_clear = 1'b0;
        tick();
        tick();
        checkOutput("mask_held", mask0, 4'b0001);
        checkOutput("error_pulse_end", error0, 0);

        // Continuous req_valid with a target changing every cycle.
        tbl[0] = 4'b0011; tbl[1] = 4'b1111; tbl[2] = 4'b0000;
        tbl[3] = 4'b1100; tbl[4] = 4'b0110; tbl[5] = 4'b1001;
        tbl[6] = 4'b0101; tbl[7] = 4'b1110; tbl[8] = 4'b0001;
        waitReady();
        for (int k = 0; k < 9; k++) begin
            req_valid  = 1'b1;
            req_target = tbl[k];
            tick();
            checkOutput($sformatf("bb_en_%0d", k), en0, (k % 3 == 0) ? 1 : 0);
            if (k == 0) checkOutput("bb_mask_clear", mask0, 0);
            if (k % 3 == 1) checkOutput($sformatf("bb_q_%0d", k), q0, tbl[k-1]);
            if (k % 3 == 2) checkOutput($sformatf("bb_done_%0d", k), done0, 1);
        end
        req_valid = 1'b0;
        tick();
        checkOutput("bb_idle_after", en0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
